// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cpu_pkg                                                         |
// | Brief    : Shared bus-select, opcode and instruction-class definitions.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [3:0] {
    ZERO      = 4'd0,
    IR_R1     = 4'd1,
    IR_R2     = 4'd2,
    IR_RD     = 4'd3,
    RF        = 4'd4,
    ALU       = 4'd5,
    PC_PLUS_4 = 4'd6,
    MEM       = 4'd7,
    PC_BRANCH = 4'd8
  } data_bus_t;

  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_LD  = 3'd1,
    CLS_ST  = 3'd2,
    CLS_BEQ = 3'd3,
    CLS_JMP = 3'd4,
    CLS_HLT = 3'd5,
    CLS_ILL = 3'd6
  } instr_class_t;

  localparam logic [31:0] c_op_alu_max = 32'd7;
  localparam logic [31:0] c_op_ld      = 32'd8;
  localparam logic [31:0] c_op_st      = 32'd9;
  localparam logic [31:0] c_op_beq     = 32'd10;
  localparam logic [31:0] c_op_jmp     = 32'd11;
  localparam logic [31:0] c_op_hlt     = 32'd15;

  // Opcode is zero-extended by the caller so wide opcode fields fall into CLS_ILL.
  function automatic instr_class_t decode_class(input logic [31:0] op);
    if (op <= c_op_alu_max) return CLS_ALU;
    else if (op == c_op_ld)  return CLS_LD;
    else if (op == c_op_st)  return CLS_ST;
    else if (op == c_op_beq) return CLS_BEQ;
    else if (op == c_op_jmp) return CLS_JMP;
    else if (op == c_op_hlt) return CLS_HLT;
    else                     return CLS_ILL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/microcode_sequencer_mem_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_wait_timer                                                  |
// | Brief    : Counts mem_ready-low cycles of one access and flags timeout.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_active,
  input  logic i_mem_ready,
  output logic o_timeout
);

  localparam int TO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] c_limit = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] r_count;
  logic            w_at_limit;

  assign w_at_limit = (r_count == c_limit);

  // Saturates at the limit so a stalled access never wraps back to a legal count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear || i_mem_ready) begin
      r_count <= '0;
    end else if (i_active && !w_at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign o_timeout = 1'b0;
    end else begin : g_timeout
      assign o_timeout = i_active && !i_mem_ready && w_at_limit;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/microcode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : microcode_sequencer                                             |
// | Brief    : Fetch/decode/execute control sequencer for the common-bus CPU.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module microcode_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imm_instruction,
  input  logic                branch_taken,
  input  logic                mem_ready,
  input  logic                resume,
  output data_bus_t           data_bus_sel,
  output logic                pc_load_en,
  output logic                ir_load_en,
  output logic                mar_load_en,
  output logic                sel_field_load_en,
  output logic                alu_src1_load_en,
  output logic                alu_src2_load_en,
  output logic                rf_write_read,
  output logic                mem_req,
  output logic                mem_we,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_code
);

  typedef enum logic [4:0] {
    S_RST    = 5'd0,  S_FETCH  = 5'd1,  S_DECODE = 5'd2,  S_R1_SEL = 5'd3,
    S_R1_RD  = 5'd4,  S_R2_SEL = 5'd5,  S_R2_RD  = 5'd6,  S_IMM_LD = 5'd7,
    S_RD_SEL = 5'd8,  S_WB     = 5'd9,  S_A_SEL  = 5'd10, S_MAR_LD = 5'd11,
    S_ST_SEL = 5'd12, S_MEM_RD = 5'd13, S_MEM_WR = 5'd14, S_BR_EVAL = 5'd15,
    S_BR_TGT = 5'd16, S_PC_INC = 5'd17, S_HALTED = 5'd18, S_FAULT = 5'd19
  } state_t;

  state_t       r_state, w_next;
  instr_class_t r_cls, w_dec_cls;
  logic [1:0]   r_fault_code, w_set_code;
  logic         w_access, w_access_next, w_timeout;

  assign w_dec_cls     = decode_class(32'(opcode));
  assign w_access      = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_access_next = (w_next == S_FETCH) || (w_next == S_MEM_RD) || (w_next == S_MEM_WR);
  assign fault_code    = r_fault_code;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_clear     (w_access_next && (w_next != r_state)),
    .i_active    (w_access),
    .i_mem_ready (mem_ready),
    .o_timeout   (w_timeout)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_RST;
      r_cls        <= CLS_ALU;
      r_fault_code <= 2'b00;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_dec_cls;
      if ((w_next == S_FAULT) && (r_state != S_FAULT)) r_fault_code <= w_set_code;
    end
  end

  always_comb begin
    w_next            = r_state;
    w_set_code        = 2'b00;
    data_bus_sel      = ZERO;
    pc_load_en        = 1'b0;
    ir_load_en        = 1'b0;
    mar_load_en       = 1'b0;
    sel_field_load_en = 1'b0;
    alu_src1_load_en  = 1'b0;
    alu_src2_load_en  = 1'b0;
    rf_write_read     = 1'b0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    halted            = 1'b0;
    fault             = 1'b0;
    case (r_state)
      S_RST: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          data_bus_sel = MEM;
          ir_load_en   = 1'b1;
          w_next       = S_DECODE;
        end else if (w_timeout) begin
          w_next     = S_FAULT;
          w_set_code = 2'b10;
        end
      end
      S_DECODE: begin
        case (w_dec_cls)
          CLS_ALU, CLS_BEQ: w_next = S_R1_SEL;
          CLS_LD, CLS_ST:   w_next = S_A_SEL;
          CLS_JMP:          w_next = S_BR_TGT;
          CLS_HLT:          w_next = S_HALTED;
          default: begin
            w_next     = S_FAULT;
            w_set_code = 2'b01;
          end
        endcase
      end
      S_R1_SEL: begin
        data_bus_sel = IR_R1; sel_field_load_en = 1'b1; w_next = S_R1_RD;
      end
      S_R1_RD: begin
        data_bus_sel = RF; alu_src1_load_en = 1'b1;
        w_next = ((r_cls == CLS_ALU) && imm_instruction) ? S_IMM_LD : S_R2_SEL;
      end
      S_R2_SEL: begin
        data_bus_sel = IR_R2; sel_field_load_en = 1'b1; w_next = S_R2_RD;
      end
      S_R2_RD: begin
        data_bus_sel = RF; alu_src2_load_en = 1'b1;
        w_next = (r_cls == CLS_BEQ) ? S_BR_EVAL : S_RD_SEL;
      end
      S_IMM_LD: begin
        data_bus_sel = IR_R2; alu_src2_load_en = 1'b1; w_next = S_RD_SEL;
      end
      S_RD_SEL: begin
        data_bus_sel = IR_RD; sel_field_load_en = 1'b1;
        w_next = (r_cls == CLS_LD) ? S_MEM_RD : S_WB;
      end
      S_WB: begin
        data_bus_sel = ALU; rf_write_read = 1'b1; w_next = S_PC_INC;
      end
      S_A_SEL: begin
        data_bus_sel = IR_R1; sel_field_load_en = 1'b1; w_next = S_MAR_LD;
      end
      S_MAR_LD: begin
        data_bus_sel = RF; mar_load_en = 1'b1;
        w_next = (r_cls == CLS_LD) ? S_RD_SEL : S_ST_SEL;
      end
      S_ST_SEL: begin
        data_bus_sel = IR_R2; sel_field_load_en = 1'b1; w_next = S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          data_bus_sel = MEM; rf_write_read = 1'b1; w_next = S_PC_INC;
        end else if (w_timeout) begin
          w_next = S_FAULT; w_set_code = 2'b10;
        end
      end
      S_MEM_WR: begin
        // Store data stays on the bus for the whole access, not just the ready cycle.
        mem_req = 1'b1; mem_we = 1'b1; data_bus_sel = RF;
        if (mem_ready) begin
          w_next = S_PC_INC;
        end else if (w_timeout) begin
          w_next = S_FAULT; w_set_code = 2'b10;
        end
      end
      S_BR_EVAL: begin
        pc_load_en   = 1'b1;
        data_bus_sel = branch_taken ? PC_BRANCH : PC_PLUS_4;
        w_next       = S_FETCH;
      end
      S_BR_TGT: begin
        data_bus_sel = PC_BRANCH; pc_load_en = 1'b1; w_next = S_FETCH;
      end
      S_PC_INC: begin
        data_bus_sel = PC_PLUS_4; pc_load_en = 1'b1; w_next = S_FETCH;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (resume) w_next = S_PC_INC;
      end
      S_FAULT: fault = 1'b1;
      default: w_next = S_RST;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_microcode_sequencer                                          |
// | Brief    : Scoreboard bench: per-cycle expected outputs queued by driver.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_microcode_sequencer;
  import cpu_pkg::*;

  typedef struct packed {
    logic [3:0] bus;
    logic [6:0] en;    // pc, ir, mar, sel_field, src1, src2, rf_write
    logic       req;
    logic       we;
    logic       hlt;
    logic       flt;
    logic [1:0] code;
  } exp_t;

  localparam logic [6:0] c_en_pc  = 7'b1000000;
  localparam logic [6:0] c_en_ir  = 7'b0100000;
  localparam logic [6:0] c_en_mar = 7'b0010000;
  localparam logic [6:0] c_en_sel = 7'b0001000;
  localparam logic [6:0] c_en_s1  = 7'b0000100;
  localparam logic [6:0] c_en_s2  = 7'b0000010;
  localparam logic [6:0] c_en_rfw = 7'b0000001;

  logic       clock, reset_n;
  logic [3:0] opcode;
  logic       imm_instruction, branch_taken, mem_ready, resume;
  data_bus_t  data_bus_sel;
  logic       pc_load_en, ir_load_en, mar_load_en, sel_field_load_en;
  logic       alu_src1_load_en, alu_src2_load_en, rf_write_read;
  logic       mem_req, mem_we, halted, fault;
  logic [1:0] fault_code;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_exp, mon_act;
  string mon_nm;
  int    n_cmp = 0;
  int    n_bad = 0;

  microcode_sequencer #(.OPCODE_W(4), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode),
    .imm_instruction(imm_instruction), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .resume(resume), .data_bus_sel(data_bus_sel),
    .pc_load_en(pc_load_en), .ir_load_en(ir_load_en), .mar_load_en(mar_load_en),
    .sel_field_load_en(sel_field_load_en), .alu_src1_load_en(alu_src1_load_en),
    .alu_src2_load_en(alu_src2_load_en), .rf_write_read(rf_write_read),
    .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .fault(fault),
    .fault_code(fault_code)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic exp_t mk(data_bus_t b, logic [6:0] en, logic rq, logic w,
                              logic h, logic f, logic [1:0] c);
    exp_t e;
    e.bus = b; e.en = en; e.req = rq; e.we = w; e.hlt = h; e.flt = f; e.code = c;
    return e;
  endfunction

  function automatic exp_t mkb(data_bus_t b, logic [6:0] en);
    return mk(b, en, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endfunction

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_act = {data_bus_sel, pc_load_en, ir_load_en, mar_load_en, sel_field_load_en,
                 alu_src1_load_en, alu_src2_load_en, rf_write_read,
                 mem_req, mem_we, halted, fault, fault_code};
      n_cmp++;
      if (mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL %s: got bus=%0d en=%b req=%b we=%b hlt=%b flt=%b code=%b, required bus=%0d en=%b req=%b we=%b hlt=%b flt=%b code=%b",
                 mon_nm, mon_act.bus, mon_act.en, mon_act.req, mon_act.we, mon_act.hlt,
                 mon_act.flt, mon_act.code, mon_exp.bus, mon_exp.en, mon_exp.req,
                 mon_exp.we, mon_exp.hlt, mon_exp.flt, mon_exp.code);
      end
    end
  end

  task automatic check_now(input string nm, input exp_t e);
    exp_t a;
    a = {data_bus_sel, pc_load_en, ir_load_en, mar_load_en, sel_field_load_en,
         alu_src1_load_en, alu_src2_load_en, rf_write_read,
         mem_req, mem_we, halted, fault, fault_code};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got bus=%0d en=%b req=%b we=%b hlt=%b flt=%b code=%b, required bus=%0d en=%b req=%b we=%b hlt=%b flt=%b code=%b",
               nm, a.bus, a.en, a.req, a.we, a.hlt, a.flt, a.code,
               e.bus, e.en, e.req, e.we, e.hlt, e.flt, e.code);
    end
  endtask

  task automatic cyc(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_dec(input logic [3:0] op, input logic imm);
    opcode = op; imm_instruction = imm; mem_ready = 1'b1;
    cyc("fetch", mk(MEM, c_en_ir, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("decode", mkb(ZERO, 7'd0));
  endtask

  task automatic reg_read2(input string tag);
    cyc({tag, "_r1sel"}, mkb(IR_R1, c_en_sel));
    cyc({tag, "_r1rd"},  mkb(RF, c_en_s1));
    cyc({tag, "_r2sel"}, mkb(IR_R2, c_en_sel));
    cyc({tag, "_r2rd"},  mkb(RF, c_en_s2));
  endtask

  task automatic addr_phase(input string tag);
    cyc({tag, "_asel"}, mkb(IR_R1, c_en_sel));
    cyc({tag, "_marld"}, mkb(RF, c_en_mar));
  endtask

  initial begin
    reset_n = 1'b0; opcode = 4'd0; imm_instruction = 1'b0; branch_taken = 1'b0;
    mem_ready = 1'b0; resume = 1'b0;
    @(posedge clock); #1;
    check_now("reset_state_direct", mkb(ZERO, 7'd0));
    cyc("reset_held", mkb(ZERO, 7'd0));
    reset_n = 1'b1;
    cyc("rst_state", mkb(ZERO, 7'd0));

    // ALU register form: 9 cycles
    fetch_dec(4'h0, 1'b0);
    reg_read2("alur");
    cyc("alur_rdsel", mkb(IR_RD, c_en_sel));
    cyc("alur_wb",    mkb(ALU, c_en_rfw));
    cyc("alur_pcinc", mkb(PC_PLUS_4, c_en_pc));

    // ALU immediate form: 8 cycles, no second RF read
    fetch_dec(4'h3, 1'b1);
    cyc("alui_r1sel", mkb(IR_R1, c_en_sel));
    cyc("alui_r1rd",  mkb(RF, c_en_s1));
    cyc("alui_immld", mkb(IR_R2, c_en_s2));
    cyc("alui_rdsel", mkb(IR_RD, c_en_sel));
    cyc("alui_wb",    mkb(ALU, c_en_rfw));
    cyc("alui_pcinc", mkb(PC_PLUS_4, c_en_pc));

    // Load with three wait cycles
    fetch_dec(4'h8, 1'b0);
    addr_phase("ld");
    cyc("ld_rdsel", mkb(IR_RD, c_en_sel));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("ld_wait", mk(ZERO, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    mem_ready = 1'b1;
    cyc("ld_done",  mk(MEM, c_en_rfw, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    cyc("ld_pcinc", mkb(PC_PLUS_4, c_en_pc));

    // Store: ready arrives on the exact timeout cycle, which must win
    fetch_dec(4'h9, 1'b0);
    addr_phase("st");
    cyc("st_stsel", mkb(IR_R2, c_en_sel));
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      cyc("st_wait", mk(RF, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
    mem_ready = 1'b1;
    cyc("st_done_at_limit", mk(RF, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
    cyc("st_pcinc", mkb(PC_PLUS_4, c_en_pc));

    // Branch taken (imm flag must be ignored for BEQ), then not taken
    fetch_dec(4'hA, 1'b1);
    reg_read2("beq_t");
    branch_taken = 1'b1;
    cyc("beq_taken", mkb(PC_BRANCH, c_en_pc));
    branch_taken = 1'b0;
    fetch_dec(4'hA, 1'b0);
    reg_read2("beq_n");
    cyc("beq_not_taken", mkb(PC_PLUS_4, c_en_pc));

    // Jump: 3 cycles
    fetch_dec(4'hB, 1'b0);
    cyc("jmp_tgt", mkb(PC_BRANCH, c_en_pc));

    // Halt for 5 cycles, resume sampled in the fifth
    fetch_dec(4'hF, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("halted", mk(ZERO, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    resume = 1'b1;
    cyc("halted_resume", mk(ZERO, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    resume = 1'b0;
    cyc("halt_pcinc", mkb(PC_PLUS_4, c_en_pc));

    // Reset asserted mid-store drops mem_req without a clock edge
    fetch_dec(4'h9, 1'b0);
    addr_phase("st2");
    cyc("st2_stsel", mkb(IR_R2, c_en_sel));
    mem_ready = 1'b0;
    cyc("st2_wait", mk(RF, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
    reset_n = 1'b0;
    cyc("rst_mid_store", mkb(ZERO, 7'd0));
    reset_n = 1'b1;
    cyc("rst_after_store", mkb(ZERO, 7'd0));

    // Fetch never completes: timeout fault, resume ignored
    for (int i = 0; i < 5; i++)
      cyc("fetch_stall", mk(ZERO, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    check_now("expired_wait_direct", mk(ZERO, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10));
    cyc("fault_timeout", mk(ZERO, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10));
    resume = 1'b1;
    cyc("fault_resume", mk(ZERO, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10));
    cyc("fault_sticky", mk(ZERO, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10));
    resume = 1'b0;

    // Illegal opcode
    reset_n = 1'b0;
    cyc("reset2", mkb(ZERO, 7'd0));
    reset_n = 1'b1;
    cyc("rst_state2", mkb(ZERO, 7'd0));
    fetch_dec(4'hC, 1'b0);
    cyc("fault_illegal", mk(ZERO, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01));
    cyc("fault_illegal_hold", mk(ZERO, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01));

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
